stopwatch_ctrl: RTL

//   Control FSM that sequences the stopwatch MM:SS BCD counter datapath.
//   - Edge-detects the debounced pause level and tracks run/pause/adjust mode.
//   - Turns clk_1hz/clk_2hz enable pulses into registered increment strobes.
//   - Resolves the seconds->minutes carry from the datapath's at-max flags.
//   - Drives the is_adj/is_sel_sec flags consumed by the display block.

---
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its tick sources, inputs and MM:SS datapath.
// master drives ticks, levels and at-max flags; slave is the controller that returns strobes and status.
interface stopwatch_ctrl_if;
   logic clk_1hz;
   logic clk_2hz;
   logic button_pause;
   logic switch_adj;
   logic switch_sel;
   logic sec_at_max;
   logic min_at_max;
   logic sec_inc;
   logic min_inc;
   logic rollover;
   logic clr;
   logic running;
   logic is_adj;
   logic is_sel_sec;

   modport master (
      output clk_1hz, clk_2hz, button_pause, switch_adj, switch_sel, sec_at_max, min_at_max,
      input  sec_inc, min_inc, rollover, clr, running, is_adj, is_sel_sec
   );

   modport slave (
      input  clk_1hz, clk_2hz, button_pause, switch_adj, switch_sel, sec_at_max, min_at_max,
      output sec_inc, min_inc, rollover, clr, running, is_adj, is_sel_sec
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM (PAUSED/RUN/ADJ) producing registered increment strobes for the MM:SS datapath.
// Define STOPWATCH_CTRL_LONGPRESS_CLR_EN to build hold-to-clear (pause held for HOLD_SEC clk_1hz ticks).
module stopwatch_ctrl (
   input logic             clk_100mhz,
   input logic             rst,
   stopwatch_ctrl_if.slave sw
);

`ifdef STOPWATCH_CTRL_LONGPRESS_CLR_EN
   parameter int HOLD_SEC = 2;
`endif

   typedef enum logic [1:0] {PAUSED, RUN, ADJ} state_t;

   state_t state;
   state_t next_state;
   logic   pause_q;
   logic   pause_rise;
   logic   hold_hit;
   logic   sec_inc_d;
   logic   min_inc_d;
   logic   rollover_d;
   logic   sec_inc_q;
   logic   min_inc_q;
   logic   rollover_q;
   logic   clr_q;
   logic   running_q;
   logic   is_adj_q;
   logic   is_sel_sec_q;

   assign pause_rise = sw.button_pause & ~pause_q;

`ifdef STOPWATCH_CTRL_LONGPRESS_CLR_EN
   localparam int HW = $clog2(HOLD_SEC + 1);

   logic [HW-1:0] hold_cnt;

   // The counter saturates at HOLD_SEC so a single press can only fire clr once.
   assign hold_hit = sw.button_pause && (state != ADJ) && sw.clk_1hz &&
                     (hold_cnt == HW'(HOLD_SEC - 1));

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         clr_q    <= 1'b0;
      end else begin
         clr_q <= hold_hit;
         if (!sw.button_pause || state == ADJ) begin
            hold_cnt <= '0;
         end else if (sw.clk_1hz && hold_cnt != HW'(HOLD_SEC)) begin
            hold_cnt <= hold_cnt + HW'(1);
         end
      end
   end
`else
   assign hold_hit = 1'b0;
   assign clr_q    = 1'b0;
`endif

   always_comb begin
      next_state = state;
      if (sw.switch_adj) begin
         next_state = ADJ;
      end else if (state == ADJ) begin
         next_state = PAUSED;
      end else if (hold_hit) begin
         next_state = PAUSED;
      end else if (pause_rise) begin
         next_state = (state == PAUSED) ? RUN : PAUSED;
      end
   end

   // Strobes follow the current state, so a tick on a transition cycle belongs to the old mode.
   always_comb begin
      sec_inc_d  = 1'b0;
      min_inc_d  = 1'b0;
      rollover_d = 1'b0;
      case (state)
         RUN: begin
            if (sw.clk_1hz) begin
               sec_inc_d  = 1'b1;
               min_inc_d  = sw.sec_at_max;
               rollover_d = sw.sec_at_max & sw.min_at_max;
            end
         end
         ADJ: begin
            if (sw.clk_2hz) begin
               sec_inc_d = sw.switch_sel;
               min_inc_d = ~sw.switch_sel;
            end
         end
         default: begin
         end
      endcase
      if (hold_hit) begin
         sec_inc_d  = 1'b0;
         min_inc_d  = 1'b0;
         rollover_d = 1'b0;
      end
   end

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         state        <= PAUSED;
         pause_q      <= 1'b0;
         sec_inc_q    <= 1'b0;
         min_inc_q    <= 1'b0;
         rollover_q   <= 1'b0;
         running_q    <= 1'b0;
         is_adj_q     <= 1'b0;
         is_sel_sec_q <= 1'b0;
      end else begin
         state        <= next_state;
         pause_q      <= sw.button_pause;
         sec_inc_q    <= sec_inc_d;
         min_inc_q    <= min_inc_d;
         rollover_q   <= rollover_d;
         running_q    <= (next_state == RUN);
         is_adj_q     <= (next_state == ADJ);
         is_sel_sec_q <= sw.switch_sel;
      end
   end

   assign sw.sec_inc    = sec_inc_q;
   assign sw.min_inc    = min_inc_q;
   assign sw.rollover   = rollover_q;
   assign sw.clr        = clr_q;
   assign sw.running    = running_q;
   assign sw.is_adj     = is_adj_q;
   assign sw.is_sel_sec = is_sel_sec_q;

endmodule
